// File: rtl/cpu_pkg.sv
// Shared CPU definitions: field widths, interface defaults, fetch FSM encoding,
// opcode and ALU-function constants used across the core.
package cpu_pkg;

  localparam int OPCODE_W    = 4;
  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_ISSUE = 2'd2
  } fetch_state_e;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_LD  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_ST  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'hA;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

endpackage

// File: rtl/pc_register.sv
// Program counter: synchronous load or increment, wrapping modulo 2^W,
// with synchronous active-low reset to zero.
module pc_register #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] pc_o
);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  // Next PC: load has priority over increment; increment wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q <= {W{1'b0}};
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one word at pc, holds it in the instruction
// register until the decoder accepts it, then advances or redirects pc.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [INSTR_W-1:0]    mem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [INSTR_W-OPCODE_W-1:0] operand,
  output logic [ADDR_W-1:0]     instr_pc,
  input  logic                  jump_en,
  input  logic [ADDR_W-1:0]     jump_addr
);

  fetch_state_e        state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]   pc_s;
  logic                handshake_s;
  logic                pc_load_s;
  logic                pc_inc_s;

  assign handshake_s = (state_q == FETCH_ISSUE) && instr_ready;
  // jump inputs only matter on the accepting cycle
  assign pc_load_s   = handshake_s && jump_en;
  assign pc_inc_s    = handshake_s && !jump_en;

  pc_register #(.W(ADDR_W)) u_pc (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .load_i     (pc_load_s),
    .load_val_i (jump_addr),
    .inc_i      (pc_inc_s),
    .pc_o       (pc_s)
  );

  // Fetch FSM next state and IR/instr_pc capture.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      FETCH_IDLE: begin
        if (run) begin
          state_d = FETCH_REQ;
        end else begin
          state_d = FETCH_IDLE;
        end
      end
      FETCH_REQ: begin
        if (mem_ack) begin
          ir_d       = mem_rdata;
          instr_pc_d = pc_s;
          state_d    = FETCH_ISSUE;
        end else begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_ISSUE: begin
        if (instr_ready) begin
          state_d = run ? FETCH_REQ : FETCH_IDLE;
        end else begin
          state_d = FETCH_ISSUE;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  // State, instruction register and issued-address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      ir_q       <= {INSTR_W{1'b0}};
      instr_pc_q <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign mem_req     = (state_q == FETCH_REQ);
  assign mem_addr    = pc_s;
  assign instr_valid = (state_q == FETCH_ISSUE);
  assign opcode      = ir_q[INSTR_W-1 -: OPCODE_W];
  assign operand     = ir_q[INSTR_W-OPCODE_W-1:0];
  assign instr_pc    = instr_pc_q;

endmodule
